tt_um_explorer: RTL and testbench

// Tiny Tapeout top for a 640x480@60 VGA "map explorer": a procedural tiled world is scrolled

---
 rtl/tt_um_explorer_if.sv | 10 +
 rtl/tt_um_explorer.sv | 151 +++++++++++++++
 tb/tb_tt_um_explorer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_explorer_if.sv
// Pad-side bundle of the Tiny Tapeout user I/O that the explorer core drives and samples.
interface tt_um_explorer_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_explorer.sv
// VGA map explorer: raster counters, a once-per-frame camera update and a registered
// TinyVGA pixel/sync output computed from a procedural tiled world.
module tt_um_explorer_core #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_um_explorer_if.slave io_if
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [7:0] ui;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] cam_x_q, cam_x_d, cam_y_q, cam_y_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] uo_q, uo_d;

  logic       frame_tick;
  logic [9:0] step;
  logic [9:0] wx, wy;
  logic       visible, hsync_n, vsync_n;
  logic [1:0] r, g, b;

  assign ui = io_if.ui_in;

  always_comb begin : raster
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // The camera and frame counter move together on the first pixel of vsync.
  assign frame_tick = (h_q == '0) && (v_q == VS_START);
  assign step       = 10'd1 << ui[5:4];

  always_comb begin : camera
    cam_x_d = cam_x_q;
    cam_y_d = cam_y_q;
    frame_d = frame_q;
    if (frame_tick) begin
      frame_d = frame_q + 8'd1;
      if (!ui[7]) begin
        if (ui[0] && !ui[1])      cam_x_d = cam_x_q + step;
        else if (ui[1] && !ui[0]) cam_x_d = cam_x_q - step;
        if (ui[2] && !ui[3])      cam_y_d = cam_y_q + step;
        else if (ui[3] && !ui[2]) cam_y_d = cam_y_q - step;
      end
    end
  end

  // 10-bit adders wrap the world naturally in both directions.
  assign wx      = h_q + cam_x_q;
  assign wy      = v_q + cam_y_q;
  assign visible = (h_q < H_VIS_W) && (v_q < V_VIS_W);
  assign hsync_n = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync_n = !((v_q >= VS_START) && (v_q < VS_END));

  always_comb begin : colour
    r = wx[7:6] ^ {2{ui[6]}};
    g = wy[7:6] ^ {2{ui[6]}};
    b = {wx[5] ^ wy[5], wx[4] ^ wy[4]} ^ {2{ui[6]}};
    if (!visible) begin
      r = '0;
      g = '0;
      b = '0;
    end
    uo_d = {hsync_n, b[0], g[0], r[0], vsync_n, b[1], g[1], r[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      cam_x_q <= '0;
      cam_y_q <= '0;
      frame_q <= '0;
      uo_q    <= 8'h88;
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      h_q     <= h_d;
      v_q     <= v_d;
      cam_x_q <= cam_x_d;
      cam_y_q <= cam_y_d;
      frame_q <= frame_d;
      uo_q    <= uo_d;
    end
  end

  assign io_if.uo_out  = uo_q;
  assign io_if.uio_out = frame_q;
  assign io_if.uio_oe  = 8'hFF;
endmodule

module tt_um_explorer #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  tt_um_explorer_if pads ();
  logic unused_inputs;

  assign pads.ui_in    = ui_in;
  assign uo_out        = pads.uo_out;
  assign uio_out       = pads.uio_out;
  assign uio_oe        = pads.uio_oe;
  assign unused_inputs = &{1'b0, ena, uio_in};

  tt_um_explorer_core #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .io_if (pads.slave)
  );
endmodule

// File: tb/tb_tt_um_explorer.sv
// Bench for tt_um_explorer: a default-timing instance for the real VGA line timing and a
// shrunk-raster instance, checked against a frame-level model of the world and camera.
module tb_tt_um_explorer;
  localparam int HV = 96, HF = 8, HS = 16, HB = 8;
  localparam int VV = 16, VF = 2, VS = 2,  VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int VTICK = VV + VF;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uio_in_v;
  logic       ena_v;
  logic [7:0] full_ui, full_uo, full_uio_out, full_uio_oe;

  int checks   = 0;
  int failures = 0;

  tt_um_explorer_if bus ();

  tt_um_explorer #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .ui_in(bus.ui_in), .uo_out(bus.uo_out), .uio_in(uio_in_v), .uio_out(bus.uio_out),
    .uio_oe(bus.uio_oe), .ena(ena_v), .clk(clk), .rst_n(rst_n)
  );

  tt_um_explorer dut_full (
    .ui_in(full_ui), .uo_out(full_uo), .uio_in(8'h5A), .uio_out(full_uio_out),
    .uio_oe(full_uio_oe), .ena(1'b1), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int move(int c, logic plus, logic minus, logic [1:0] spd);
    int s;
    s = 1 << spd;
    if (plus && !minus) return (c + s) % 1024;
    if (minus && !plus) return (c + 1024 - s) % 1024;
    return c;
  endfunction

  function automatic logic [7:0] model_pixel(int h, int v, int cx, int cy, logic [7:0] ui);
    int wx, wy, r, g, b;
    logic hs_n, vs_n;
    wx = (h + cx) % 1024;
    wy = (v + cy) % 1024;
    r  = (wx / 64) % 4;
    g  = (wy / 64) % 4;
    b  = 2 * (((wx / 32) % 2) ^ ((wy / 32) % 2)) + (((wx / 16) % 2) ^ ((wy / 16) % 2));
    if (ui[6]) begin
      r = 3 - r;
      g = 3 - g;
      b = 3 - b;
    end
    if (!(h < HV && v < VV)) begin
      r = 0;
      g = 0;
      b = 0;
    end
    hs_n = !(h >= HV + HF && h < HV + HF + HS);
    vs_n = !(v >= VV + VF && v < VV + VF + VS);
    return {hs_n, b[0], g[0], r[0], vs_n, b[1], g[1], r[1]};
  endfunction

  int         m_n, m_cx, m_cy, m_frame, m_sh, m_sv;
  logic [7:0] m_uo;
  bit         m_valid;

  // m_n counts pixels since reset release; the output after edge k shows pixel k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_cx    <= 0;
      m_cy    <= 0;
      m_frame <= 0;
      m_uo    <= 8'h88;
      m_valid <= 1'b0;
      m_sh    <= 0;
      m_sv    <= 0;
    end else begin
      m_uo    <= model_pixel(m_n % HT, (m_n / HT) % VT, m_cx, m_cy, bus.ui_in);
      m_sh    <= m_n % HT;
      m_sv    <= (m_n / HT) % VT;
      m_valid <= 1'b1;
      m_n     <= m_n + 1;
      if ((m_n % HT) == 0 && ((m_n / HT) % VT) == VTICK) begin
        m_frame <= (m_frame + 1) % 256;
        if (!bus.ui_in[7]) begin
          m_cx <= move(m_cx, bus.ui_in[0], bus.ui_in[1], bus.ui_in[5:4]);
          m_cy <= move(m_cy, bus.ui_in[2], bus.ui_in[3], bus.ui_in[5:4]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_show(input int h, input int v, input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_sh == h && m_sv == v) && n < 2 * FRAME);
    if (!(m_valid && m_sh == h && m_sv == v)) begin
      checks++;
      failures++;
      $display("FAIL %s: pixel (%0d,%0d) not reached within %0d cycles", what, h, v, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus.ui_in = 8'h00;
    full_ui   = 8'h00;
    uio_in_v  = 8'hA5;
    ena_v     = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.uo_out !== 8'h88)
      begin failures++; $display("FAIL reset_uo: got %h want 88", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00)
      begin failures++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
    checks++; if (bus.uio_oe !== 8'hFF)
      begin failures++; $display("FAIL reset_uio_oe: got %h want FF", bus.uio_oe); end
    checks++; if (full_uo !== 8'h88)
      begin failures++; $display("FAIL reset_full_uo: got %h want 88", full_uo); end
    checks++; if (full_uio_oe !== 8'hFF)
      begin failures++; $display("FAIL reset_full_uio_oe: got %h want FF", full_uio_oe); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_timing();
    int cnt, low, per;
    bit fell;
    cnt  = 0;
    fell = 1'b0;
    while (cnt < 2000 && !fell) begin
      @(negedge clk);
      cnt++;
      if (cnt == 33) begin
        checks++; if (full_uo !== 8'h8C)
          begin failures++; $display("FAIL full_pixel_32_0: got %h want 8C", full_uo); end
      end
      if (cnt == 65) begin
        checks++; if (full_uo !== 8'h98)
          begin failures++; $display("FAIL full_pixel_64_0: got %h want 98", full_uo); end
      end
      if (full_uo[7] === 1'b0) fell = 1'b1;
    end
    checks++; if (!fell || cnt != 657)
      begin failures++; $display("FAIL full_hsync_first_fall: got %0d want 657", cnt); end
    low = 0;
    while (full_uo[7] === 1'b0 && low < 2000) begin
      @(negedge clk);
      low++;
    end
    checks++; if (low != 96)
      begin failures++; $display("FAIL full_hsync_low: got %0d want 96", low); end
    per = low;
    while (full_uo[7] === 1'b1 && per < 2000) begin
      @(negedge clk);
      per++;
    end
    checks++; if (per != 800)
      begin failures++; $display("FAIL full_hsync_period: got %0d want 800", per); end
    checks++; if (full_uo[3] !== 1'b1 || full_uio_out !== 8'h00)
      begin failures++; $display("FAIL full_line1_state: got vs=%b frame=%h want 1,00", full_uo[3], full_uio_out); end
  endtask

  task automatic test_small_timing();
    int c, low, per;
    c = 0;
    while (bus.uo_out[3] !== 1'b0 && c < 2 * FRAME) begin
      @(negedge clk);
      c++;
    end
    checks++; if (bus.uo_out[3] !== 1'b0)
      begin failures++; $display("FAIL vsync_fall: not seen in %0d cycles", c); end
    checks++; if (bus.uio_out !== 8'(m_frame) || bus.uio_out !== 8'h01)
      begin failures++; $display("FAIL frame_at_vsync: got %h want %h", bus.uio_out, 8'(m_frame)); end
    low = 0;
    while (bus.uo_out[3] === 1'b0 && low < 2 * FRAME) begin
      @(negedge clk);
      low++;
    end
    checks++; if (low != VS * HT)
      begin failures++; $display("FAIL vsync_low: got %0d want %0d", low, VS * HT); end
    per = low;
    while (bus.uo_out[3] === 1'b1 && per < 2 * FRAME) begin
      @(negedge clk);
      per++;
    end
    checks++; if (per != FRAME)
      begin failures++; $display("FAIL vsync_period: got %0d want %0d", per, FRAME); end
    c = 0;
    while (bus.uo_out[7] !== 1'b0 && c < 2 * HT) begin
      @(negedge clk);
      c++;
    end
    low = 0;
    while (bus.uo_out[7] === 1'b0 && low < 2 * HT) begin
      @(negedge clk);
      low++;
    end
    checks++; if (low != HS)
      begin failures++; $display("FAIL hsync_low_small: got %0d want %0d", low, HS); end
  endtask

  task automatic test_camera_right();
    do_reset();
    bus.ui_in = 8'h01;
    for (int i = 0; i < 3; i++) wait_show(0, VTICK, "right_tick");
    bus.ui_in = 8'h00;
    wait_show(60, 0, "right_60");
    checks++; if (bus.uo_out !== 8'hCC)
      begin failures++; $display("FAIL cam_right_pixel60: got %h want CC", bus.uo_out); end
    @(negedge clk);
    checks++; if (bus.uo_out !== 8'h98)
      begin failures++; $display("FAIL cam_right_pixel61: got %h want 98", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h03)
      begin failures++; $display("FAIL cam_right_frame: got %h want 03", bus.uio_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.ui_in = 8'h32;
    wait_show(0, VTICK, "wrap_tick");
    bus.ui_in = 8'h00;
    wait_show(0, 0, "wrap_00");
    checks++; if (bus.uo_out !== 8'hDD)
      begin failures++; $display("FAIL wrap_left_pixel0: got %h want DD", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h01)
      begin failures++; $display("FAIL wrap_frame: got %h want 01", bus.uio_out); end
    wait_show(8, 0, "wrap_8");
    checks++; if (bus.uo_out !== 8'h88)
      begin failures++; $display("FAIL wrap_left_pixel8: got %h want 88", bus.uo_out); end
    bus.ui_in = 8'h0F;
    wait_show(0, VTICK, "both_tick");
    bus.ui_in = 8'h00;
    wait_show(0, 0, "both_00");
    checks++; if (bus.uo_out !== 8'hDD)
      begin failures++; $display("FAIL both_pressed_no_move: got %h want DD", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h02)
      begin failures++; $display("FAIL both_pressed_frame: got %h want 02", bus.uio_out); end
  endtask

  task automatic test_freeze_invert();
    do_reset();
    bus.ui_in = 8'hB1;
    wait_show(0, VTICK, "freeze_tick");
    bus.ui_in = 8'h40;
    wait_show(0, 0, "invert_00");
    checks++; if (bus.uo_out !== 8'hFF)
      begin failures++; $display("FAIL invert_pixel0: got %h want FF", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h01)
      begin failures++; $display("FAIL freeze_frame: got %h want 01", bus.uio_out); end
    wait_show(56, 0, "freeze_56");
    checks++; if (bus.uo_out !== 8'hBB)
      begin failures++; $display("FAIL freeze_cam_pixel56: got %h want BB", bus.uo_out); end
    wait_show(100, 0, "invert_blank");
    checks++; if (bus.uo_out !== 8'h88)
      begin failures++; $display("FAIL invert_blanking: got %h want 88", bus.uo_out); end
  endtask

  task automatic test_random();
    int idx;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.ui_in = 8'($urandom);
      uio_in_v  = 8'($urandom);
      ena_v     = 1'($urandom);
      idx       = $urandom_range(FRAME - 1);
      wait_show(idx % HT, idx / HT, "random");
      checks++; if (bus.uo_out !== m_uo)
        begin failures++; $display("FAIL random_pixel(%0d,%0d): got %h want %h", m_sh, m_sv, bus.uo_out, m_uo); end
      checks++; if (bus.uio_out !== 8'(m_frame))
        begin failures++; $display("FAIL random_frame: got %h want %h", bus.uio_out, 8'(m_frame)); end
    end
  endtask

  task automatic test_reset_midframe();
    bus.ui_in = 8'h31;
    wait_show(0, VTICK, "pre_reset_tick");
    wait_show(40, 5, "pre_reset_pos");
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.uo_out !== 8'h88 || bus.uio_out !== 8'h00)
      begin failures++; $display("FAIL async_reset: got uo=%h uio=%h want 88,00", bus.uo_out, bus.uio_out); end
    @(negedge clk);
    rst_n     = 1'b1;
    bus.ui_in = 8'h40;
    @(negedge clk);
    checks++; if (bus.uo_out !== 8'hFF)
      begin failures++; $display("FAIL restart_pixel0: got %h want FF", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00)
      begin failures++; $display("FAIL restart_frame: got %h want 00", bus.uio_out); end
    wait_show(56, 0, "restart_56");
    checks++; if (bus.uo_out !== 8'hBB)
      begin failures++; $display("FAIL restart_cam_zero: got %h want BB", bus.uo_out); end
  endtask

  initial begin
    test_reset();
    test_full_timing();
    test_small_timing();
    test_camera_right();
    test_wrap();
    test_freeze_invert();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
